// File: rtl/ntt_ctrl_fsm.sv
// Sequencer for the NTT/INTT butterfly datapath: stage/issue/drain timing plus RAM load/unload.
// Optional CTRL_CYCCNT_EN adds a saturating busy-cycle counter output cyc_cnt_o.
module ntt_ctrl_fsm #(
  parameter int unsigned N             = 256,
  parameter int unsigned COEF_PER_WORD = 2,
  parameter int unsigned BF_PAR        = 1,
  parameter int unsigned STAGES        = 7,
  parameter int unsigned PIPE_LAT      = 11,
  parameter int unsigned RD_LAT        = 1,
  localparam int unsigned Words        = N / COEF_PER_WORD,
  localparam int unsigned Issue        = N / (2 * BF_PAR),
  localparam int unsigned IdxW         = (Words > 1) ? $clog2(Words) : 1,
  localparam int unsigned StW          = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      mode_i,
  input  logic            in_valid_i,
  output logic            busy_o,
  output logic            newloop_o,
  output logic [StW-1:0]  stage_o,
  output logic            rd_en_o,
  output logic [IdxW-1:0] rd_idx_o,
  output logic            wen_o,
  output logic [IdxW-1:0] wr_idx_o,
  output logic            out_valid_o,
`ifdef CTRL_CYCCNT_EN
  output logic [31:0]     cyc_cnt_o,
`endif
  output logic            done_o
);

  localparam logic [1:0] ModeNtt  = 2'b00;
  localparam logic [1:0] ModeIntt = 2'b01;
  localparam logic [1:0] ModeIn   = 2'b10;
  localparam logic [1:0] ModeOut  = 2'b11;

  localparam logic [IdxW-1:0] IssueLast = IdxW'(Issue - 1);
  localparam logic [IdxW-1:0] WordsLast = IdxW'(Words - 1);
  localparam logic [StW-1:0]  StageLast = StW'(STAGES - 1);

  typedef enum logic [2:0] {
    StIdle, StPrep, StIssue, StDrain, StLoad, StUnload, StFin
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [StW-1:0]  stage_q, stage_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            first_q, first_d;
  logic            rd_done_q, rd_done_d;
  logic            issue_en, unload_en, load_acc, last_stage;

  // Write-path delay line: rd_en/rd_idx of the issue phase, PIPE_LAT cycles late.
  logic [PIPE_LAT-1:0] wv_q;
  logic [IdxW-1:0]     wi_q [PIPE_LAT];
  // Read-data delay line for unload: valid and "last word" markers.
  logic [RD_LAT-1:0]   ov_q, ol_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    stage_d    = stage_q;
    idx_d      = idx_q;
    rd_done_d  = rd_done_q;
    first_d    = 1'b0;
    issue_en   = (state_q == StIssue);
    unload_en  = (state_q == StUnload) && !rd_done_q;
    load_acc   = (state_q == StLoad) && in_valid_i;
    last_stage = (mode_q == ModeIntt) ? (stage_q == '0) : (stage_q == StageLast);

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d    = mode_i;
          idx_d     = '0;
          rd_done_d = 1'b0;
          first_d   = mode_i[1];
          unique case (mode_i)
            ModeNtt:  begin state_d = StPrep; stage_d = '0;        end
            ModeIntt: begin state_d = StPrep; stage_d = StageLast; end
            ModeIn:   state_d = StLoad;
            ModeOut:  state_d = StUnload;
          endcase
        end
      end
      StPrep: begin
        idx_d   = '0;
        state_d = StIssue;
      end
      StIssue: begin
        if (idx_q == IssueLast) state_d = StDrain;
        else                    idx_d   = idx_q + 1'b1;
      end
      StDrain: begin
        // Next stage may only start once the final write of this one has gone out.
        if (wv_q[PIPE_LAT-1] && (wi_q[PIPE_LAT-1] == IssueLast)) begin
          if (last_stage) begin
            state_d = StFin;
          end else begin
            state_d = StPrep;
            stage_d = (mode_q == ModeIntt) ? stage_q - 1'b1 : stage_q + 1'b1;
          end
        end
      end
      StLoad: begin
        if (load_acc) begin
          if (idx_q == WordsLast) state_d = StFin;
          else                    idx_d   = idx_q + 1'b1;
        end
      end
      StUnload: begin
        if (unload_en) begin
          if (idx_q == WordsLast) rd_done_d = 1'b1;
          else                    idx_d     = idx_q + 1'b1;
        end
        if (ol_q[RD_LAT-1]) state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      mode_q    <= ModeNtt;
      stage_q   <= '0;
      idx_q     <= '0;
      first_q   <= 1'b0;
      rd_done_q <= 1'b0;
      wv_q      <= '0;
      ov_q      <= '0;
      ol_q      <= '0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) wi_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      stage_q   <= stage_d;
      idx_q     <= idx_d;
      first_q   <= first_d;
      rd_done_q <= rd_done_d;
      wv_q[0]   <= issue_en;
      wi_q[0]   <= idx_q;
      ov_q[0]   <= unload_en;
      ol_q[0]   <= unload_en && (idx_q == WordsLast);
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        wv_q[i] <= wv_q[i-1];
        wi_q[i] <= wi_q[i-1];
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        ov_q[i] <= ov_q[i-1];
        ol_q[i] <= ol_q[i-1];
      end
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign newloop_o   = (state_q == StPrep) || first_q;
  assign stage_o     = stage_q;
  assign rd_en_o     = issue_en || unload_en;
  assign rd_idx_o    = rd_en_o ? idx_q : '0;
  assign wen_o       = wv_q[PIPE_LAT-1] || load_acc;
  assign wr_idx_o    = load_acc ? idx_q : (wv_q[PIPE_LAT-1] ? wi_q[PIPE_LAT-1] : '0);
  assign out_valid_o = ov_q[RD_LAT-1];
  assign done_o      = (state_q == StFin);

`ifdef CTRL_CYCCNT_EN
  logic [31:0] cyc_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_cnt_q <= '0;
    end else if ((state_q == StIdle) && start_i) begin
      cyc_cnt_q <= '0;
    end else if (busy_o && (cyc_cnt_q != 32'hFFFF_FFFF)) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end
  end

  assign cyc_cnt_o = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_ntt_ctrl_fsm.sv
// Scoreboard bench for ntt_ctrl_fsm: stimulus pushes expected events, a negedge monitor pops them.
module tb_ntt_ctrl_fsm;

  localparam int StageLen = 140;  // 1 prep + 128 issue + 11 drain
  localparam int DoneNtt  = 981;
  localparam int IssueN   = 128;
  localparam int PipeLat  = 11;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       in_valid = 1'b0;
  logic       busy_o, newloop_o, rd_en_o, wen_o, out_valid_o, done_o;
  logic [2:0] stage_o;
  logic [6:0] rd_idx_o, wr_idx_o;
`ifdef CTRL_CYCCNT_EN
  logic [31:0] cyc_cnt_o;
`endif

  ntt_ctrl_fsm #(.RD_LAT(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start),
    .mode_i      (mode),
    .in_valid_i  (in_valid),
    .busy_o      (busy_o),
    .newloop_o   (newloop_o),
    .stage_o     (stage_o),
    .rd_en_o     (rd_en_o),
    .rd_idx_o    (rd_idx_o),
    .wen_o       (wen_o),
    .wr_idx_o    (wr_idx_o),
    .out_valid_o (out_valid_o),
`ifdef CTRL_CYCCNT_EN
    .cyc_cnt_o   (cyc_cnt_o),
`endif
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;  // -1: value not checked
  } ev_t;

  ev_t q_nl[$], q_rd[$], q_wr[$], q_ov[$], q_dn[$];
  int  checks = 0;
  int  failures = 0;
  int  t0 = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL unexpected_%s: event seen at cycle %0d, required none", name, cyc);
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst_ni) begin
      if (newloop_o) begin
        if (q_nl.size() == 0) unexpected("newloop");
        else begin
          e = q_nl.pop_front();
          chk("newloop_cycle", cyc, e.cyc);
          if (e.val >= 0) chk("newloop_stage", stage_o, e.val);
        end
      end
      if (rd_en_o) begin
        if (q_rd.size() == 0) unexpected("rd_en");
        else begin
          e = q_rd.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_idx", rd_idx_o, e.val);
        end
      end
      if (wen_o) begin
        if (q_wr.size() == 0) unexpected("wen");
        else begin
          e = q_wr.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_idx", wr_idx_o, e.val);
        end
      end
      if (out_valid_o) begin
        if (q_ov.size() == 0) unexpected("out_valid");
        else begin
          e = q_ov.pop_front();
          chk("out_valid_cycle", cyc, e.cyc);
        end
      end
      if (done_o) begin
        if (q_dn.size() == 0) unexpected("done");
        else begin
          e = q_dn.pop_front();
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  function automatic int pending();
    return q_nl.size() + q_rd.size() + q_wr.size() + q_ov.size() + q_dn.size();
  endfunction

  task automatic push_expect(input logic [1:0] m);
    int base;
    unique case (m)
      2'b00, 2'b01: begin
        for (int s = 0; s < 7; s++) begin
          base = t0 + 1 + StageLen * s;
          q_nl.push_back('{cyc: base, val: (m == 2'b01) ? 6 - s : s});
          for (int i = 0; i < IssueN; i++) begin
            q_rd.push_back('{cyc: base + 1 + i, val: i});
            q_wr.push_back('{cyc: base + 1 + PipeLat + i, val: i});
          end
        end
        q_dn.push_back('{cyc: t0 + DoneNtt, val: 0});
      end
      2'b10: begin
        q_nl.push_back('{cyc: t0 + 1, val: -1});
        for (int k = 0; k < 128; k++) q_wr.push_back('{cyc: t0 + 1 + 2 * k, val: k});
        q_dn.push_back('{cyc: t0 + 256, val: 0});
      end
      2'b11: begin
        q_nl.push_back('{cyc: t0 + 1, val: -1});
        for (int i = 0; i < 128; i++) begin
          q_rd.push_back('{cyc: t0 + 1 + i, val: i});
          q_ov.push_back('{cyc: t0 + 3 + i, val: -1});
        end
        q_dn.push_back('{cyc: t0 + 131, val: 0});
      end
    endcase
  endtask

  // Issues start in cycle t0; returns #1 into cycle t0+1 with mode scrambled.
  task automatic start_op(input logic [1:0] m);
    @(posedge clk); #1;
    t0    = cyc;
    mode  = m;
    start = 1'b1;
    push_expect(m);
    @(posedge clk); #1;
    start = 1'b0;
    mode  = ~m;
    chk("busy_after_start", busy_o, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (pending() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_pending_events"}, pending(), 0);
    @(posedge clk); #1;
    chk({name, "_busy_after_done"}, busy_o, 0);
    chk({name, "_done_low"}, done_o, 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, busy_o, 0);
    chk({name, "_newloop"}, newloop_o, 0);
    chk({name, "_rd_en"}, rd_en_o, 0);
    chk({name, "_wen"}, wen_o, 0);
    chk({name, "_wr_idx"}, wr_idx_o, 0);
    chk({name, "_rd_idx"}, rd_idx_o, 0);
    chk({name, "_out_valid"}, out_valid_o, 0);
    chk({name, "_done"}, done_o, 0);
    chk({name, "_stage"}, stage_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;

    // NTT, stages 0..6
    start_op(2'b00);
    wait_idle("ntt");
`ifdef CTRL_CYCCNT_EN
    chk("cyc_cnt_ntt", cyc_cnt_o, DoneNtt);
`endif

    // INTT, stages 6..0
    start_op(2'b01);
    wait_idle("intt");

    // IN with in_valid alternating 1,0 starting in the first LOAD cycle
    start_op(2'b10);
    for (int k = 1; k < 260; k++) begin
      in_valid = (k % 2 == 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle("load");

    // OUT with RD_LAT=2
    start_op(2'b11);
    wait_idle("unload");

    // Reset during stage 3 drain (cycles 550..560), while writes are in flight
    start_op(2'b00);
    repeat (554) @(posedge clk);
    #2;
    chk("pre_reset_wen", wen_o, 1);
    rst_ni = 1'b0;
    #1;
    chk_all_zero("async_reset");
    q_nl.delete(); q_rd.delete(); q_wr.delete(); q_ov.delete(); q_dn.delete();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_reset_busy", busy_o, 0);

    // Restart after reset, with start pulses (and mode changes) while busy
    start_op(2'b00);
    repeat (98) @(posedge clk);
    #1;
    start = 1'b1;
    mode  = 2'b11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    start = 1'b1;
    mode  = 2'b10;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("ntt_restart");
`ifdef CTRL_CYCCNT_EN
    chk("cyc_cnt_restart", cyc_cnt_o, DoneNtt);
    repeat (5) @(posedge clk);
    #1;
    chk("cyc_cnt_hold", cyc_cnt_o, DoneNtt);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
